// File: rtl/huff_decode9.sv
// huff_decode9: serial prefix-code decoder with a loadable 9-entry code table
module huff_decode9 (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       load_en,
    input  logic [3:0] load_idx,
    input  logic [7:0] load_code,
    input  logic [3:0] load_len,
    input  logic       decode_begin,
    input  logic       decode_stop,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       sym_valid,
    output logic [3:0] sym,
    output logic [3:0] sym_len,
    output logic       decode_err,
    output logic       busy,
    output logic [7:0] sym_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    logic [1:0] r_state;
    logic       r_valid [9];
    logic [7:0] r_code  [9];
    logic [3:0] r_len   [9];
    logic [7:0] r_acc;
    logic [3:0] r_cnt;
    logic       r_sym_valid;
    logic [3:0] r_sym;
    logic [3:0] r_sym_len;
    logic       r_err;
    logic [7:0] r_sym_count;
    logic [7:0] w_acc_n;
    logic [3:0] w_cnt_n;
    logic [8:0] w_match;
    logic       w_hit;
    logic [3:0] w_idx;

    assign w_acc_n    = {r_acc[6:0], bit_in};
    assign w_cnt_n    = r_cnt + 4'd1;
    assign sym_valid  = r_sym_valid;
    assign sym        = r_sym;
    assign sym_len    = r_sym_len;
    assign decode_err = r_err;
    assign sym_count  = r_sym_count;
    assign busy       = r_state != IDLE;

    // An entry matches when its length equals the bits gathered and its low len bits agree
    for (genvar g = 0; g < 9; g++) begin : g_match
        assign w_match[g] = r_valid[g] && r_len[g] == w_cnt_n &&
                            ((r_code[g] ^ w_acc_n) & (8'hFF >> (4'd8 - r_len[g]))) == 8'd0;
    end

    // Priority encode: the lowest matching index wins
    always_comb begin
        w_hit = 1'b0;
        w_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_idx = 4'(i);
            end
        end
    end

    // Table writes, honoured only while idle; a bad length invalidates the entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 9; i++) begin
                r_valid[i] <= 1'b0;
                r_code[i]  <= 8'd0;
                r_len[i]   <= 4'd0;
            end
        end else if (load_en && r_state == IDLE && load_idx <= 4'd8) begin
            r_valid[load_idx] <= load_len != 4'd0 && load_len <= 4'd8;
            r_code[load_idx]  <= load_code;
            r_len[load_idx]   <= load_len;
        end
    end

    // Decode FSM: shift bits in, emit symbol or error pulses, track saturating count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_acc       <= 8'd0;
            r_cnt       <= 4'd0;
            r_sym_valid <= 1'b0;
            r_sym       <= 4'd0;
            r_sym_len   <= 4'd0;
            r_err       <= 1'b0;
            r_sym_count <= 8'd0;
        end else begin
            r_sym_valid <= 1'b0;
            r_err       <= 1'b0;
            if (r_state != IDLE && decode_stop) begin
                r_state <= IDLE;
                r_acc   <= 8'd0;
                r_cnt   <= 4'd0;
            end else if (decode_begin) begin
                r_state     <= RUN;
                r_acc       <= 8'd0;
                r_cnt       <= 4'd0;
                r_sym_count <= 8'd0;
            end else if (r_state == RUN && bit_valid) begin
                if (w_hit) begin
                    r_sym_valid <= 1'b1;
                    r_sym       <= w_idx;
                    r_sym_len   <= w_cnt_n;
                    r_acc       <= 8'd0;
                    r_cnt       <= 4'd0;
                    r_sym_count <= r_sym_count == 8'hFF ? r_sym_count : r_sym_count + 8'd1;
                end else if (w_cnt_n == 4'd8) begin
                    r_err   <= 1'b1;
                    r_state <= ERR;
                    r_acc   <= 8'd0;
                    r_cnt   <= 4'd0;
                end else begin
                    r_acc <= w_acc_n;
                    r_cnt <= w_cnt_n;
                end
            end
        end
    end
endmodule

// File: doc/huff_decode9.md
HUFF_DECODE9 -- requirements
Module: huff_decode9

Interface
REQ-001 SHALL have ports: CLK  input  1  sole clock, rising-edge.
REQ-002 SHALL have: nRST  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: load_en  input  1  write one code-table entry this cycle.
REQ-004 SHALL have: load_idx  input  4  table entry / symbol index, 0..8.
REQ-005 SHALL have: load_code  input  8  codeword, right-aligned; first bit received = bit [load_len-1].
REQ-006 SHALL have: load_len  input  4  codeword length, 1..8.
REQ-007 SHALL have: decode_begin  input  1  one-cycle start pulse.
REQ-008 SHALL have: decode_stop  input  1  one-cycle abort/finish pulse.
REQ-009 SHALL have: bit_valid  input  1  bit_in is valid this cycle.
REQ-010 SHALL have: bit_in  input  1  serial code bit, MSB of codeword first.
REQ-011 SHALL have: sym_valid  output  1  one-cycle pulse, symbol decoded.
REQ-012 SHALL have: sym  output  4  decoded symbol index.
REQ-013 SHALL have: sym_len  output  4  length of the matched codeword.
REQ-014 SHALL have: decode_err  output  1  one-cycle pulse, 8 bits received with no match.
REQ-015 SHALL have: busy  output  1  high in RUN or ERR.
REQ-016 SHALL have: sym_count  output  8  symbols decoded since last decode_begin, saturating.

Function
REQ-017 SHALL hold a 9-entry table {valid, code[7:0], len[3:0]}; load_len of 0 or >8, or load_idx >8, SHALL write nothing (idx>8) or clear the entry's valid bit (bad len).
REQ-018 SHALL implement states IDLE, RUN, ERR; table writes SHALL be accepted only in IDLE and ignored otherwise.
REQ-019 IDLE: decode_begin -> RUN, clearing shift register acc[7:0], bit counter cnt[3:0], and sym_count.
REQ-020 RUN with bit_valid: acc_n = {acc[6:0], bit_in}, cnt_n = cnt+1; entry i matches when valid, len == cnt_n, and code[len-1:0] == acc_n[len-1:0].
REQ-021 On match, the lowest matching index SHALL win; next edge: sym_valid=1, sym=index, sym_len=cnt_n, acc and cnt cleared, sym_count+1 (saturating at 255).
REQ-022 Latency: sym_valid SHALL assert exactly one cycle after the cycle carrying the final code bit; back-to-back symbols SHALL decode with no idle cycle.
REQ-023 No match and cnt_n == 8: next edge decode_err=1 for one cycle, acc/cnt cleared, state -> ERR.
REQ-024 ERR SHALL ignore bits; decode_begin -> RUN (re-arm as REQ-019); decode_stop -> IDLE.
REQ-025 RUN: decode_stop SHALL take priority over a same-cycle bit_valid; bit dropped, acc/cnt cleared, -> IDLE, no sym_valid/decode_err.
REQ-026 decode_begin while in RUN SHALL restart (REQ-019); a bit in that cycle is dropped.
REQ-027 bit_valid low SHALL leave acc, cnt, and state unchanged; gaps of any length are allowed.
REQ-028 sym and sym_len SHALL hold their last value between pulses; sym_valid and decode_err SHALL never assert in the same cycle.

Reset
REQ-029 nRST low SHALL immediately force IDLE, all table valid bits 0, acc=0, cnt=0, and every output 0, including mid-decode.
REQ-030 After nRST release, no output SHALL change until a load or decode_begin occurs.

Verification
REQ-031 Load idx0 code 2'b00 len2, idx1 2'b01 len2, idx2 3'b100 len3; begin; bits 0,1,1,0,0,0,0 -> sym 1 (len 2), then 2 (len 3), then 0 (len 2), sym_count=3.
REQ-032 Load idx4 code 1'b1 len1 only; begin; bits 0 x8 -> decode_err pulse after 8th bit, busy=1 in ERR; next bits ignored; decode_begin -> RUN, bit 1 -> sym 4.
REQ-033 Duplicate entries idx3 and idx7, both code 3'b101 len3; bits 1,0,1 -> sym 3 only.
REQ-034 RUN with acc holding 2 bits; decode_stop with bit_valid same cycle -> IDLE, no pulse; load_en in RUN -> table unchanged (verified by later decode).
REQ-035 Assert nRST mid-codeword -> outputs 0 asynchronously; after release and begin without reload, any 8 bits -> decode_err.
REQ-036 Decode 300 symbols of code 1'b0 len1 continuously -> 300 sym_valid pulses, one per cycle, sym_count saturates at 255.
